mdu_ctrl: RTL and testbench

- Multiply/divide sequencing unit for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU.
- Owns the HI/LO registers and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E.
- Models multi-cycle latency with a busy counter.
- Generates the stall request that the hazard logic ORs into the global pipeline stall, so that no HI/LO user in D proceeds while an operation is pending.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_arith.sv | 57 +++++
 rtl/mdu_ctrl.sv | 108 ++++++++++
 tb/tb_mdu_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encoding, default latencies and FSM states for the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int C_MULT_LAT = 5;
  localparam int C_DIV_LAT  = 10;
  localparam int C_CNT_W    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_lat_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational MULT/MULTU/DIV/DIVU datapath with div-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic        w_sgn;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvsSafe;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_qOut;
  logic [31:0] w_rOut;

  assign w_prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prodU = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  assign w_sgn     = (op == MD_DIV);
  assign w_dvd     = (w_sgn && a[31]) ? (32'd0 - a) : a;
  assign w_dvs     = (w_sgn && b[31]) ? (32'd0 - b) : b;
  assign w_dvsSafe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
  assign w_q       = w_dvd / w_dvsSafe;
  assign w_r       = w_dvd % w_dvsSafe;
  assign w_qOut    = (w_sgn && (a[31] ^ b[31])) ? (32'd0 - w_q) : w_q;
  assign w_rOut    = (w_sgn && a[31]) ? (32'd0 - w_r) : w_r;

  assign div0 = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  begin res_hi = w_prodS[63:32]; res_lo = w_prodS[31:0]; end
      MD_MULTU: begin res_hi = w_prodU[63:32]; res_lo = w_prodU[31:0]; end
      MD_DIV,
      MD_DIVU:  begin res_hi = w_rOut;         res_lo = w_qOut;        end
      default:  begin res_hi = 32'd0;          res_lo = 32'd0;         end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : E-stage multiply/divide sequencer owning HI/LO, busy counter
//               and the HI/LO hazard stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = C_MULT_LAT,
  parameter int DIV_LAT  = C_DIV_LAT,
  parameter int CNT_W    = C_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  mdu_state_e       r_state;
  mdu_state_e       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pendHi;
  logic [31:0]      r_pendLo;
  logic             r_pendDiv0;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [31:0]      w_resHi;
  logic [31:0]      w_resLo;
  logic             w_div0;
  logic             w_latOp;
  logic             w_accept;
  logic             w_commit;
  logic             w_idleStart;
  logic             w_isDiv;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (w_resHi),
    .res_lo (w_resLo),
    .div0   (w_div0)
  );

  assign w_latOp     = start && is_lat_op(op);
  assign w_idleStart = start && (r_state == ST_IDLE);
  assign w_accept    = w_latOp && (r_state == ST_IDLE);
  assign w_commit    = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
  assign w_isDiv     = (op == MD_DIV) || (op == MD_DIVU);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_nextState = ST_RUN;
      ST_RUN:  if (w_commit) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_pendHi   <= 32'd0;
      r_pendLo   <= 32'd0;
      r_pendDiv0 <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt      <= w_isDiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        r_pendHi   <= w_resHi;
        r_pendLo   <= w_resLo;
        r_pendDiv0 <= w_div0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // A divide by zero still burns its latency but leaves HI/LO alone.
      if (w_commit && !r_pendDiv0) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
      if (w_idleStart && (op == MD_MTHI)) r_hi <= a;
      if (w_idleStart && (op == MD_MTLO)) r_lo <= a;
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = d_uses_md && (busy || w_latOp);

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  md_op_e      op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  int          nCmp = 0;
  int          nErr = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .md_stall  (md_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) assert (!(start && busy)) else $error("start asserted while busy");
  end

  function automatic int exp_lat(input md_op_e o);
    if (o == MD_MULT || o == MD_MULTU) return 5;
    if (o == MD_DIV || o == MD_DIVU)   return 10;
    return 0;
  endfunction

  // Reference: MIPS HI/LO semantics in 64-bit integer arithmetic.
  task automatic model(input md_op_e o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    case (o)
      MD_MULT:  begin sp = sx * sy; expHi = sp[63:32]; expLo = sp[31:0]; end
      MD_MULTU: begin up = ux * uy; expHi = up[63:32]; expLo = up[31:0]; end
      MD_DIV:   if (y != 0) begin sq = sx / sy; sr = sx % sy; expHi = sr[31:0]; expLo = sq[31:0]; end
      MD_DIVU:  if (y != 0) begin uq = ux / uy; ur = ux % uy; expHi = ur[31:0]; expLo = uq[31:0]; end
      MD_MTHI:  expHi = x;
      MD_MTLO:  expLo = x;
      default:  ;
    endcase
  endtask

  // Issues one op and waits for busy to drop; returns the observed busy length.
  task automatic run_op(input md_op_e o, input logic [31:0] x, input logic [31:0] y,
                        output int nBusy);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    nBusy = 0;
    while (busy && nBusy < 40) begin
      nBusy++;
      @(negedge clk);
    end
    model(o, x, y);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MD_NONE; a = 32'd0; b = 32'd0; d_uses_md = 1'b0;
    repeat (3) @(negedge clk);
    nCmp++; if (busy !== 1'b0)    begin nErr++; $display("FAIL reset_busy got %0b want 0", busy); end
    nCmp++; if (hi !== 32'd0)     begin nErr++; $display("FAIL reset_hi got %h want 0", hi); end
    nCmp++; if (lo !== 32'd0)     begin nErr++; $display("FAIL reset_lo got %h want 0", lo); end
    nCmp++; if (md_stall !== 1'b0) begin nErr++; $display("FAIL reset_stall got %0b want 0", md_stall); end
    reset = 1'b0;
    expHi = 32'd0; expLo = 32'd0;
  endtask

  task automatic check_op(input string name, input md_op_e o, input logic [31:0] x,
                          input logic [31:0] y);
    int n;
    run_op(o, x, y, n);
    nCmp++; if (n != exp_lat(o)) begin nErr++; $display("FAIL %s_lat got %0d want %0d", name, n, exp_lat(o)); end
    nCmp++; if (hi !== expHi)    begin nErr++; $display("FAIL %s_hi got %h want %h", name, hi, expHi); end
    nCmp++; if (lo !== expLo)    begin nErr++; $display("FAIL %s_lo got %h want %h", name, lo, expLo); end
  endtask

  task automatic test_mult();
    check_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3);
    nCmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin nErr++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffa", hi, lo); end
    check_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3);
    nCmp++; if (hi !== 32'h2 || lo !== 32'hFFFFFFFA) begin nErr++; $display("FAIL multu_const got %h_%h want 00000002_fffffffa", hi, lo); end
  endtask

  task automatic test_div();
    check_op("div",    MD_DIV,  32'hFFFFFFF9, 32'd2);
    nCmp++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin nErr++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", hi, lo); end
    check_op("divu",   MD_DIVU, 32'd7, 32'd2);
    check_op("divovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF);
    nCmp++; if (hi !== 32'h0 || lo !== 32'h80000000) begin nErr++; $display("FAIL divovf_const got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_div0();
    int n;
    run_op(MD_MTHI, 32'h11, 32'd0, n);
    run_op(MD_MTLO, 32'h22, 32'd0, n);
    check_op("divu0", MD_DIVU, 32'h1234, 32'd0);
    nCmp++; if (hi !== 32'h11 || lo !== 32'h22) begin nErr++; $display("FAIL divu0_keep got %h_%h want 00000011_00000022", hi, lo); end
    check_op("div0",  MD_DIV,  32'hFFFF0000, 32'd0);
  endtask

  task automatic test_mthi_mtlo();
    d_uses_md = 1'b1;
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'hDEADBEEF;
    #1;
    nCmp++; if (md_stall !== 1'b0) begin nErr++; $display("FAIL mthi_stall got %0b want 0", md_stall); end
    @(negedge clk);
    nCmp++; if (hi !== 32'hDEADBEEF || busy !== 1'b0) begin nErr++; $display("FAIL mthi got hi=%h busy=%0b want deadbeef/0", hi, busy); end
    op = MD_MTLO; a = 32'h1234;
    @(negedge clk);
    nCmp++; if (lo !== 32'h1234 || hi !== 32'hDEADBEEF || busy !== 1'b0) begin nErr++; $display("FAIL mtlo got hi=%h lo=%h busy=%0b want deadbeef/00001234/0", hi, lo, busy); end
    start = 1'b0; op = MD_NONE; d_uses_md = 1'b0;
    expHi = 32'hDEADBEEF; expLo = 32'h1234;
  endtask

  task automatic test_stall();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      d_uses_md = (pass == 0);
      @(negedge clk);
      start = 1'b1; op = MD_MULT; a = 32'd6; b = 32'd7;
      #1;
      nCmp++; if (md_stall !== d_uses_md) begin nErr++; $display("FAIL stall_start got %0b want %0b", md_stall, d_uses_md); end
      @(negedge clk);
      start = 1'b0; op = MD_NONE;
      n = 0;
      while (busy && n < 40) begin
        nCmp++; if (md_stall !== d_uses_md) begin nErr++; $display("FAIL stall_busy%0d got %0b want %0b", n, md_stall, d_uses_md); end
        n++;
        @(negedge clk);
      end
      model(MD_MULT, 32'd6, 32'd7);
      nCmp++; if (n != 5) begin nErr++; $display("FAIL stall_lat got %0d want 5", n); end
      nCmp++; if (md_stall !== 1'b0 || lo !== 32'd42) begin nErr++; $display("FAIL stall_end got stall=%0b lo=%h want 0/0000002a", md_stall, lo); end
    end
    d_uses_md = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    run_op(MD_MTHI, 32'h55, 32'd0, n);
    @(negedge clk);
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (2) @(negedge clk);
    nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL rmid_busy3 got %0b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expHi = 32'd0; expLo = 32'd0;
    nCmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin nErr++; $display("FAIL rmid_clear got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    repeat (12) @(negedge clk);
    nCmp++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin nErr++; $display("FAIL rmid_late got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
  endtask

  task automatic test_random();
    md_op_e      o;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = md_op_e'($urandom_range(0, 6));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = {28'd0, y[3:0]};
      check_op($sformatf("rnd%0d", i), o, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_mthi_mtlo();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
`default_nettype wire
